time_entry: RTL

- Keypad digit-entry stage directly upstream of the timer's BCD counter chain (minutes units, seconds tens mod-6, seconds units).
- Collects up to three BCD digits in M:SS form and validates that seconds-tens is at most 5.
- On start, presents the digits on the counters' parallel-load bus and issues a one-cycle active-low load strobe.
- Locks out entry while the timer runs, until the counters report zero or the user cancels.

---
 rtl/time_entry_pkg.sv | 22 ++
 rtl/time_entry_edge_detect.sv | 22 ++
 rtl/time_entry.sv | 138 +++++++++++++
 3 files changed

// File: rtl/time_entry_pkg.sv
// Shared types and constants for the time_entry keypad stage: state encodings,
// digit limits and the packed M:SS load payload.
package time_entry_pkg;

  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned DIGIT_MAX        = 9;
  localparam int unsigned MAX_SEC_TENS_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } time_t;

endpackage

// File: rtl/time_entry_edge_detect.sv
// Registered rising-edge detector: pulse is high for one cycle after d is
// sampled high following a low sample.
module edge_detect (
  input  logic clk,
  input  logic clrn,
  input  logic d,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= d;
      pulse <= d & ~prev;
    end
  end

endmodule

// File: rtl/time_entry.sv
// Keypad M:SS digit entry in front of the timer counter chain; validates, loads
// the counters with a one-cycle loadn strobe and locks out entry while running.
// Optional key_valid debounce filter enabled by defining KEY_DEBOUNCE_EN.
module time_entry
  import time_entry_pkg::*;
#(
`ifdef KEY_DEBOUNCE_EN
  parameter int unsigned DEBOUNCE_CYCLES = 4,
`endif
  parameter int unsigned MAX_SEC_TENS = MAX_SEC_TENS_DEF
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       loadn,
  output logic [1:0] digit_cnt,
  output logic       entry_err,
  output logic       locked
);

  state_t     st, nxt;
  time_t      dig, dig_n;
  logic [1:0] cnt_n;
  logic       err_n;
  logic       armed;
  logic       key_filt;
  logic       key_ev, start_ev, cancel_ev;
  logic       digit_ev, time_ok;

`ifdef KEY_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;
  logic            raw_q;

  // Filtered level follows raw key_valid only once it has been stable long enough
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      raw_q    <= 1'b0;
      db_cnt   <= '0;
      key_filt <= 1'b0;
    end else begin
      raw_q <= key_valid;
      if (key_valid != raw_q)
        db_cnt <= '0;
      else if (db_cnt != DB_W'(DEBOUNCE_CYCLES))
        db_cnt <= db_cnt + DB_W'(1);
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES))
        key_filt <= raw_q;
    end
  end
`else
  assign key_filt = key_valid;
`endif

  edge_detect u_key_ed    (.clk(clk), .clrn(clrn), .d(key_filt), .pulse(key_ev));
  edge_detect u_start_ed  (.clk(clk), .clrn(clrn), .d(start),    .pulse(start_ev));
  edge_detect u_cancel_ed (.clk(clk), .clrn(clrn), .d(cancel),   .pulse(cancel_ev));

  assign digit_ev = key_ev && (key_code <= 4'(DIGIT_MAX));
  assign time_ok  = dig.sec_tens <= 4'(MAX_SEC_TENS);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) st <= ST_IDLE;
    else       st <= nxt;
  end

  // Next state: cancel beats start beats digit
  always_comb begin
    nxt = st;
    if (cancel_ev) begin
      nxt = ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:   if (!start_ev && digit_ev) nxt = ST_ENTRY;
        ST_ENTRY:  if (start_ev && time_ok) nxt = ST_LOAD;
        ST_LOAD:   nxt = ST_LOCKED;
        ST_LOCKED: if (armed && timer_zero) nxt = ST_IDLE;
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath next values; a start in the same cycle as a digit swallows the digit
  always_comb begin
    dig_n = dig;
    cnt_n = digit_cnt;
    err_n = entry_err;
    if (cancel_ev) begin
      dig_n = '0;
      cnt_n = 2'd0;
      err_n = 1'b0;
    end else if (st == ST_LOCKED && nxt == ST_IDLE) begin
      dig_n = '0;
      cnt_n = 2'd0;
    end else if (st == ST_IDLE || st == ST_ENTRY) begin
      if (start_ev) begin
        if (st == ST_ENTRY && !time_ok) err_n = 1'b1;
      end else if (digit_ev) begin
        dig_n.min_ones = dig.sec_tens;
        dig_n.sec_tens = dig.sec_ones;
        dig_n.sec_ones = key_code;
        cnt_n          = (digit_cnt == 2'd3) ? 2'd3 : digit_cnt + 2'd1;
        err_n          = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dig       <= '0;
      digit_cnt <= 2'd0;
      entry_err <= 1'b0;
      locked    <= 1'b0;
      loadn     <= 1'b1;
      armed     <= 1'b0;
    end else begin
      dig       <= dig_n;
      digit_cnt <= cnt_n;
      entry_err <= err_n;
      locked    <= (nxt == ST_LOCKED);
      loadn     <= (nxt != ST_LOAD);
      armed     <= (st == ST_LOCKED);
    end
  end

  assign min_ones = dig.min_ones;
  assign sec_tens = dig.sec_tens;
  assign sec_ones = dig.sec_ones;

endmodule
